sgb_packet_rx: RTL and testbench
================================

Name: sgb_packet_rx

Overview:
- Decodes SGB command packets that the GB core signals on its joypad select lines (joy_p54) and delivers the bytes to the SGB command/SNES-side logic through a ready/valid byte stream.
- Generalises the fixed single-packet decode to multi-packet transfers with configurable depth, glitch filtering and timeout.
- Only complete packets are delivered. A packet becomes visible only after its stop bit is accepted.

Parameters:
- MAX_PACKETS, 7: upper clamp on the number of packets per transfer (1..7).
- FIFO_DEPTH, 32: byte FIFO depth. Must be a power of 2 and at least 16.
- FILT, 2: number of consecutive clk_en samples a joy_p54 value must hold before it is accepted (1..15).
- TIMEOUT_W, 16: width of the idle timeout counter. The timeout fires at all-ones.
- HDR_LEN, 1: 1 = take the transfer length from byte0[2:0] of packet 0. 0 = every packet is a standalone transfer.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clk_en  in  1  GB clock enable; sampling and timeout advance only when this is high
- joy_p54  in  2  [0]=P14, [1]=P15 from the GB core, active-low selects
- out_data  out  8  FIFO head byte
- out_first  out  1  head byte is byte 0 of packet 0 of a transfer
- out_last  out  1  head byte is byte 15 of the final packet of a transfer
- out_valid  out  1  FIFO not empty (committed data only)
- out_ready  in  1  consumer accept; a pop happens when out_valid and out_ready are both high
- fifo_level  out  $clog2(FIFO_DEPTH)+1  committed byte count
- overflow  out  1  sticky: a packet was dropped for lack of space
- clr_overflow  in  1  clears overflow
- abort  out  1  one-cycle pulse when a packet in progress is discarded
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs are 0, the state is IDLE, all FIFO pointers are 0, and the filtered level is 2'b11. A reset mid-packet discards the speculative bytes with no abort pulse.
- Filter: a raw value is accepted after FILT consecutive identical clk_en samples. The decoder sees only the filtered level, so FILT clk_en cycles of latency are added.
- Symbol encoding (filtered level):
  - 00 = reset pulse
  - 10 (P14 low) = bit 0
  - 01 (P15 low) = bit 1
  - 11 = release
- Bit order: bits are LSB first within a byte, and bytes arrive in order.
- States and transitions:
  - IDLE: on 00, go to START_REL.
  - START_REL: on 11, go to BIT.
  - BIT: on 10 or 01, shift in the bit and go to BIT_REL.
  - BIT_REL: on 11, bit count +1. After 128 bits go to STOP, otherwise go to BIT.
  - STOP: on 10, go to STOP_REL. On 01, abort.
  - STOP_REL: on 11, commit the packet and go to IDLE.
- Reset pulse during BIT, BIT_REL or STOP: abort the current packet, clear the transfer packet index, and go to START_REL.
- Timeout: the counter clears on every filtered-level change and counts clk_en cycles while busy. At all-ones it aborts and the state goes to IDLE.
- Abort: speculative write pointer := commit pointer, abort pulses for 1 cycle, and the transfer index resets to 0.
- FIFO: 10 bits wide (data, first, last). Three pointers:
  - rd: consumer read pointer.
  - wr_spec: advances when each byte completes.
  - wr_commit: set equal to wr_spec one cycle after STOP_REL accepts 11.
- fifo_level and out_valid derive from wr_commit - rd. A pop and a commit in the same cycle are both honoured.
- Space check when leaving START_REL: if FIFO_DEPTH - level < 16, the packet is decoded but not written. overflow is set and no commit occurs. Decoding continues so the line state stays tracked.
- overflow set and clr_overflow in the same cycle: set wins.
- Transfer length, HDR_LEN=1:
  - L = byte0[2:0] of packet 0. 0 is treated as 1. L is clamped to MAX_PACKETS.
  - pkt_idx increments at each commit and returns to 0 after L packets.
  - first is tagged on byte 0 when pkt_idx=0. last is tagged on byte 15 when pkt_idx=L-1.
- A dropped packet restarts the transfer: pkt_idx returns to 0.
- HDR_LEN=0: every packet is tagged first on byte 0 and last on byte 15.

Test Plan:
- Single packet, byte0=0x01, bytes k=0x10+k, stop=10, FILT=2 -> 16 bytes popped in order. out_first on 0x01, out_last on 0x1F. fifo_level peaks at 16. abort never pulses.
- Two-packet transfer, byte0=0x02 -> 32 bytes delivered. out_first only on byte 0, out_last only on byte 31. None of the bytes are visible before the packet's stop bit.
- Reset pulse after 70 bits of packet 0, then a full packet -> abort pulses once, fifo_level stays 0, and only the 16 new bytes are delivered.
- Stop symbol 01 instead of 10 -> abort pulse, fifo_level=0, state goes to IDLE.
- out_ready held low, FIFO_DEPTH=32, three packets sent -> first two committed (level=32), third dropped with overflow=1. clr_overflow clears it. A 1-cycle glitch of 00 with FILT=2 is ignored.
- Line frozen at 10 mid-bit with TIMEOUT_W=4 -> abort after 15 clk_en cycles, busy=0. A synchronous reset mid-packet leaves all outputs 0.

Source files
------------

// File: rtl/sgb_packet_rx.sv
// SGB joypad-line packet receiver: glitch-filtered symbol decode feeding
// a commit-on-stop byte FIFO with transfer first/last tagging.
module sgb_packet_rx #(
  parameter int MAX_PACKETS = 7,
  parameter int FIFO_DEPTH  = 32,
  parameter int FILT        = 2,
  parameter int TIMEOUT_W   = 16,
  parameter int HDR_LEN     = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_en,
  input  logic [1:0]                  joy_p54,
  output logic [7:0]                  out_data,
  output logic                        out_first,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  input  logic                        clr_overflow,
  output logic                        abort,
  output logic                        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = 4;

  typedef enum logic [2:0] {
    IDLE, START_REL, BIT, BIT_REL, STOP, STOP_REL
  } state_t;

  state_t               state;
  logic [1:0]           cand, lvl, lvl_d;
  logic [CW-1:0]        fcnt, fcnt_d;
  logic [TIMEOUT_W-1:0] tmo;
  logic [6:0]           sr;
  logic [7:0]           new_byte;
  logic [6:0]           bcnt;
  logic [2:0]           pkt_idx, xlen;
  logic                 drop, commit_pend;
  logic [PW-1:0]        rd, wr_spec, wr_commit, level;
  logic [9:0]           mem [FIFO_DEPTH];
  logic [9:0]           head;
  logic                 sym_bit, we, kill, no_room, pop;
  logic                 tag_first, tag_last;

  function automatic logic [2:0] clamp_len(input logic [2:0] v);
    logic [2:0] r;
    r = (v == 3'd0) ? 3'd1 : v;
    if (r > 3'(MAX_PACKETS)) r = 3'(MAX_PACKETS);
    return r;
  endfunction

  always_comb begin
    fcnt_d = CW'(1);
    if (joy_p54 == cand)
      fcnt_d = (fcnt >= CW'(FILT)) ? fcnt : fcnt + CW'(1);
    lvl_d = lvl;
    if (clk_en && fcnt_d >= CW'(FILT))
      lvl_d = joy_p54;
  end

  assign sym_bit  = lvl[0] ^ lvl[1];
  assign new_byte = {lvl == 2'b01, sr};
  assign level    = wr_commit - rd;
  assign no_room  = (PW'(FIFO_DEPTH) - level) < PW'(16);
  assign busy     = (state != IDLE);
  assign kill     = busy && (&tmo);
  assign pop      = out_valid && out_ready;

  assign tag_first = (bcnt[6:3] == 4'd0) &&
                     ((HDR_LEN == 0) || (pkt_idx == 3'd0));
  assign tag_last  = (bcnt[6:3] == 4'd15) &&
                     ((HDR_LEN == 0) || (pkt_idx == xlen - 3'd1));
  assign we = !kill && (state == BIT) && sym_bit &&
              (bcnt[2:0] == 3'd7) && !drop;

  always_ff @(posedge clk)
    if (we) mem[wr_spec[AW-1:0]] <= {tag_first, tag_last, new_byte};

  // Head is gated so nothing stale leaks out while the FIFO is empty
  assign head       = mem[rd[AW-1:0]];
  assign out_valid  = (level != '0);
  assign out_data   = out_valid ? head[7:0] : 8'h00;
  assign out_first  = out_valid & head[9];
  assign out_last   = out_valid & head[8];
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (reset) begin
      cand        <= 2'b11;
      fcnt        <= CW'(FILT);
      lvl         <= 2'b11;
      state       <= IDLE;
      tmo         <= '0;
      sr          <= '0;
      bcnt        <= '0;
      pkt_idx     <= '0;
      xlen        <= '0;
      drop        <= 1'b0;
      commit_pend <= 1'b0;
      rd          <= '0;
      wr_spec     <= '0;
      wr_commit   <= '0;
      overflow    <= 1'b0;
      abort       <= 1'b0;
    end else begin
      abort       <= 1'b0;
      commit_pend <= 1'b0;
      if (clk_en) begin
        cand <= joy_p54;
        fcnt <= fcnt_d;
        lvl  <= lvl_d;
      end
      if (state == IDLE || lvl_d != lvl) tmo <= '0;
      else if (clk_en) tmo <= tmo + TIMEOUT_W'(1);
      if (commit_pend) wr_commit <= wr_spec;
      if (pop) rd <= rd + PW'(1);
      if (clr_overflow) overflow <= 1'b0;
      if (kill) begin
        abort   <= 1'b1;
        wr_spec <= wr_commit;
        pkt_idx <= '0;
        state   <= IDLE;
      end else begin
        unique case (state)
          IDLE:
            if (lvl == 2'b00) state <= START_REL;
          START_REL:
            if (lvl == 2'b11) begin
              state <= BIT;
              bcnt  <= '0;
              drop  <= no_room;
              if (no_room) overflow <= 1'b1;
            end
          BIT:
            if (lvl == 2'b00) begin
              abort   <= 1'b1;
              wr_spec <= wr_commit;
              pkt_idx <= '0;
              state   <= START_REL;
            end else if (sym_bit) begin
              sr    <= new_byte[7:1];
              state <= BIT_REL;
              if (we) wr_spec <= wr_spec + PW'(1);
              if (bcnt == 7'd7 && pkt_idx == 3'd0)
                xlen <= clamp_len(new_byte[2:0]);
            end
          BIT_REL:
            if (lvl == 2'b00) begin
              abort   <= 1'b1;
              wr_spec <= wr_commit;
              pkt_idx <= '0;
              state   <= START_REL;
            end else if (lvl == 2'b11) begin
              bcnt  <= bcnt + 7'd1;
              state <= (bcnt == 7'd127) ? STOP : BIT;
            end
          STOP:
            if (lvl == 2'b10) begin
              state <= STOP_REL;
            end else if (lvl != 2'b11) begin
              abort   <= 1'b1;
              wr_spec <= wr_commit;
              pkt_idx <= '0;
              state   <= (lvl == 2'b00) ? START_REL : IDLE;
            end
          STOP_REL:
            if (lvl == 2'b11) begin
              state <= IDLE;
              if (drop) begin
                pkt_idx <= '0;
              end else begin
                commit_pend <= 1'b1;
                pkt_idx <= ((HDR_LEN == 0) || (pkt_idx + 3'd1 >= xlen))
                         ? 3'd0 : pkt_idx + 3'd1;
              end
            end
          default:
            state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sgb_packet_rx.sv
// Bench for sgb_packet_rx: random packets and handshake stalls checked
// against a queue model of the expected tagged byte stream.
module tb_sgb_packet_rx;

  localparam int FD   = 32;
  localparam int FILT = 2;
  localparam int TW   = 6;
  localparam int MAXP = 7;

  logic       clk = 1'b0;
  logic       reset, clk_en, out_ready, clr_overflow;
  logic [1:0] joy_p54;
  logic [7:0] out_data;
  logic       out_first, out_last, out_valid;
  logic [5:0] fifo_level;
  logic       overflow, abort, busy;

  int checks = 0;
  int errors = 0;
  int abort_cnt = 0;
  int peak = 0;
  bit peak_clr = 1'b0;

  logic [7:0] pkt [16];
  logic [9:0] exp_q [$];

  sgb_packet_rx #(
    .MAX_PACKETS(MAXP), .FIFO_DEPTH(FD), .FILT(FILT),
    .TIMEOUT_W(TW), .HDR_LEN(1)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .joy_p54(joy_p54),
    .out_data(out_data), .out_first(out_first), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overflow(overflow),
    .clr_overflow(clr_overflow), .abort(abort), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (abort) abort_cnt <= abort_cnt + 1;
    if (peak_clr) peak <= 0;
    else if (int'(fifo_level) > peak) peak <= int'(fifo_level);
  end

  function automatic int exp_len(input logic [7:0] b0);
    int l;
    l = int'(b0[2:0]);
    if (l == 0) l = 1;
    if (l > MAXP) l = MAXP;
    return l;
  endfunction

  function automatic int dur();
    return int'($urandom_range(FILT + 1, FILT + 3));
  endfunction

  task automatic model_packet(input int p, input int l);
    for (int k = 0; k < 16; k++)
      exp_q.push_back({1'(p == 0 && k == 0), 1'(k == 15 && p == l - 1), pkt[k]});
  endtask

  task automatic rand_pkt(input int lsel);
    for (int k = 0; k < 16; k++) pkt[k] = 8'($urandom);
    pkt[0][2:0] = 3'(lsel);
  endtask

  // n clk_en-qualified samples of symbol v
  task automatic hold(input logic [1:0] v, input int n);
    int c = 0;
    while (c < n) begin
      @(negedge clk);
      joy_p54 = v;
      clk_en = ($urandom_range(0, 3) != 0);
      if (clk_en) c++;
    end
  endtask

  task automatic send_packet(input int nbits, input logic [1:0] stop_sym,
                             input bit do_stop, input bit do_rel);
    hold(2'b00, dur());
    hold(2'b11, dur());
    for (int i = 0; i < nbits; i++) begin
      hold(pkt[i / 8][i % 8] ? 2'b01 : 2'b10, dur());
      hold(2'b11, dur());
    end
    if (do_stop) hold(stop_sym, dur());
    if (do_rel) begin
      hold(2'b11, dur());
      hold(2'b11, FILT + 1);
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic pop_byte(output logic [9:0] got, output bit ok);
    ok = 1'b0;
    got = '0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (out_valid && $urandom_range(0, 3) != 0) begin
        got = {out_first, out_last, out_data};
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        ok = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; clk_en = 1'b0; joy_p54 = 2'b11;
    out_ready = 1'b0; clr_overflow = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_data, out_first, out_last, out_valid, fifo_level, overflow, abort, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0",
        {out_data, out_first, out_last, out_valid, fifo_level, overflow, abort, busy});
    end
    reset = 1'b0;
    hold(2'b11, 4);
    checks++;
    if ({out_valid, fifo_level, busy, abort} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle got=%h exp=0", {out_valid, fifo_level, busy, abort});
    end
  endtask

  task automatic test_single();
    logic [9:0] got, e;
    bit ok;
    int a0 = abort_cnt;
    peak_clr = 1'b1; @(negedge clk); peak_clr = 1'b0;
    pkt[0] = 8'h01;
    for (int k = 1; k < 16; k++) pkt[k] = 8'h10 + 8'(k);
    model_packet(0, 1);
    send_packet(128, 2'b10, 1'b1, 1'b1);
    checks++;
    if (fifo_level !== 6'd16) begin
      errors++; $display("FAIL single_level got=%0d exp=16", fifo_level);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_byte(got, ok);
      checks++;
      if (!ok || got !== e) begin
        errors++; $display("FAIL single_byte got=%h exp=%h ok=%0d", got, e, ok);
      end
    end
    checks++;
    if (peak != 16 || abort_cnt != a0) begin
      errors++; $display("FAIL single_peak_abort peak=%0d exp=16 aborts=%0d exp=%0d", peak, abort_cnt, a0);
    end
  endtask

  task automatic test_multi();
    logic [9:0] got, e;
    bit ok;
    int l;
    for (int it = 0; it < 3; it++) begin
      rand_pkt($urandom_range(0, 2));
      l = exp_len(pkt[0]);
      for (int p = 0; p < l; p++) begin
        if (p > 0) rand_pkt($urandom_range(0, 7));
        model_packet(p, l);
        send_packet(128, 2'b10, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (fifo_level !== 6'(16 * p)) begin
          errors++; $display("FAIL multi_prestop_level got=%0d exp=%0d", fifo_level, 16 * p);
        end
        hold(2'b11, dur());
        hold(2'b11, FILT + 1);
        repeat (3) @(negedge clk);
        checks++;
        if (fifo_level !== 6'(16 * (p + 1))) begin
          errors++; $display("FAIL multi_commit_level got=%0d exp=%0d", fifo_level, 16 * (p + 1));
        end
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        pop_byte(got, ok);
        checks++;
        if (!ok || got !== e) begin
          errors++; $display("FAIL multi_byte got=%h exp=%h ok=%0d", got, e, ok);
        end
      end
    end
  endtask

  task automatic test_reset_pulse();
    logic [9:0] got, e;
    bit ok;
    int a0 = abort_cnt;
    rand_pkt($urandom_range(0, 7));
    send_packet(70, 2'b10, 1'b0, 1'b0);
    hold(2'b00, dur());
    repeat (3) @(negedge clk);
    checks++;
    if (abort_cnt != a0 + 1 || fifo_level !== 6'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rpulse_abort aborts=%0d exp=%0d level=%0d busy=%b exp level=0 busy=1",
        abort_cnt, a0 + 1, fifo_level, busy);
    end
    rand_pkt(1);
    model_packet(0, 1);
    send_packet(128, 2'b10, 1'b1, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_byte(got, ok);
      checks++;
      if (!ok || got !== e) begin
        errors++; $display("FAIL rpulse_byte got=%h exp=%h ok=%0d", got, e, ok);
      end
    end
    checks++;
    if (abort_cnt != a0 + 1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rpulse_after aborts=%0d exp=%0d valid=%b exp=0", abort_cnt, a0 + 1, out_valid);
    end
  endtask

  task automatic test_bad_stop();
    int a0 = abort_cnt;
    rand_pkt(1);
    send_packet(128, 2'b01, 1'b1, 1'b1);
    checks++;
    if (abort_cnt != a0 + 1 || fifo_level !== 6'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_stop aborts=%0d exp=%0d level=%0d busy=%b exp level=0 busy=0",
        abort_cnt, a0 + 1, fifo_level, busy);
    end
  endtask

  task automatic test_overflow();
    logic [9:0] got, e;
    bit ok;
    int a0 = abort_cnt;
    for (int p = 0; p < 3; p++) begin
      rand_pkt($urandom_range(0, 1));
      if (p < 2) model_packet(0, 1);
      send_packet(128, 2'b10, 1'b1, 1'b1);
      if (p == 1) begin
        checks++;
        if (fifo_level !== 6'd32 || overflow !== 1'b0) begin
          errors++; $display("FAIL ovf_full level=%0d exp=32 ovf=%b exp=0", fifo_level, overflow);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1 || fifo_level !== 6'd32 || abort_cnt != a0) begin
      errors++;
      $display("FAIL ovf_drop ovf=%b exp=1 level=%0d exp=32 aborts=%0d exp=%0d",
        overflow, fifo_level, abort_cnt, a0);
    end
    hold(2'b00, 1);
    hold(2'b11, 6);
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL glitch_busy got=%b exp=0", busy);
    end
    @(negedge clk); clr_overflow = 1'b1;
    @(negedge clk); clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got=%b exp=0", overflow);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_byte(got, ok);
      checks++;
      if (!ok || got !== e) begin
        errors++; $display("FAIL ovf_byte got=%h exp=%h ok=%0d", got, e, ok);
      end
    end
    checks++;
    if (fifo_level !== 6'd0) begin
      errors++; $display("FAIL ovf_empty got=%0d exp=0", fifo_level);
    end
  endtask

  task automatic test_timeout();
    int a0 = abort_cnt;
    int n = 0;
    bit seen = 1'b0;
    rand_pkt(1);
    send_packet(20, 2'b10, 1'b0, 1'b0);
    while (!seen && n < 300) begin
      @(negedge clk);
      if (abort) begin
        seen = 1'b1;
      end else begin
        joy_p54 = 2'b10;
        clk_en = ($urandom_range(0, 3) != 0);
        if (clk_en) n++;
      end
    end
    checks++;
    if (!seen || n < (1 << TW) - 1 + FILT || n > (1 << TW) + FILT) begin
      errors++;
      $display("FAIL timeout_time seen=%b samples=%0d exp=%0d..%0d",
        seen, n, (1 << TW) - 1 + FILT, (1 << TW) + FILT);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fifo_level !== 6'd0 || abort_cnt != a0 + 1) begin
      errors++;
      $display("FAIL timeout_after busy=%b level=%0d aborts=%0d exp busy=0 level=0 aborts=%0d",
        busy, fifo_level, abort_cnt, a0 + 1);
    end
  endtask

  task automatic test_mid_reset();
    logic [9:0] got, e;
    bit ok;
    int a0 = abort_cnt;
    rand_pkt(1);
    send_packet(40, 2'b10, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    joy_p54 = 2'b11;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_data, out_first, out_last, out_valid, fifo_level, overflow, abort, busy} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got=%h exp=0",
        {out_data, out_first, out_last, out_valid, fifo_level, overflow, abort, busy});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (abort_cnt != a0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_abort aborts=%0d exp=%0d busy=%b exp=0", abort_cnt, a0, busy);
    end
    rand_pkt(0);
    model_packet(0, 1);
    send_packet(128, 2'b10, 1'b1, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_byte(got, ok);
      checks++;
      if (!ok || got !== e) begin
        errors++; $display("FAIL midreset_byte got=%h exp=%h ok=%0d", got, e, ok);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_reset_pulse();
    test_bad_stop();
    test_overflow();
    test_timeout();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
